mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, registered (1-cycle read latency) RAM between the instruction-fetch port and the MEM-stage data port of the pipelined RV32 core.
- Sits between the core's iaddr/idata and daddr/ddata_r/ddata_w/mem_read/mem_write pins and a unified memory.
- Grants one access per cycle, data-priority with a starvation guard for fetch.
- Returns per-port valid pulses and stall signals that the core's hazard logic uses to freeze PC and IF/ID.

Parameters:
- DATA_SIZE, 32, data word width.
- ADDR_SIZE, 10, word address width.
- MAX_D_STREAK, 3, max consecutive cycles fetch may be denied while requesting; next cycle fetch wins. Legal range ≥1.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- CLEAR  input  1  synchronous flush (branch taken).
- if_req  input  1  fetch request.
- if_addr  input  ADDR_SIZE  fetch word address.
- if_rdata  output  DATA_SIZE  fetched instruction.
- if_valid  output  1  if_rdata valid this cycle.
- if_stall  output  1  fetch request not granted this cycle.
- d_read  input  1  data load request.
- d_write  input  1  data store request.
- d_addr  input  ADDR_SIZE  data word address.
- d_wdata  input  DATA_SIZE  store data.
- d_rdata  output  DATA_SIZE  load data.
- d_valid  output  1  data access completed (load data valid / store done).
- d_stall  output  1  data request not granted this cycle.
- mem_addr  output  ADDR_SIZE  RAM address.
- mem_wdata  output  DATA_SIZE  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_re  output  1  RAM read enable.
- mem_rdata  input  DATA_SIZE  RAM read data, valid the cycle after mem_re.

Behaviour:
- d_req = d_read | d_write. d_read & d_write together is illegal; treat it as a write (assertion flags it).
- Grant is combinational, same cycle:
  - grant_d = d_req & !(if_req & streak==MAX_D_STREAK).
  - grant_if = if_req & !grant_d.
- if_stall = if_req & !grant_if.
- d_stall = d_req & !grant_d.
- Requesters hold req/addr/wdata stable while stalled.
- Memory drive:
  - grant_d: mem_addr=d_addr, mem_we=d_write, mem_re=d_read, mem_wdata=d_wdata.
  - grant_if: mem_addr=if_addr, mem_re=1, mem_we=0.
  - No grant: mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
- Response owner register resp_owner ∈ {OWN_NONE, OWN_IF, OWN_D}, loaded every cycle from that cycle's grant (OWN_NONE if no grant).
- Latency is exactly 1 cycle from grant to valid:
  - if_valid = (resp_owner==OWN_IF).
  - d_valid = (resp_owner==OWN_D).
- Read data:
  - if_rdata = mem_rdata when if_valid, else 0.
  - d_rdata = mem_rdata when d_valid and the granted op was a read; otherwise 0. The op type is registered alongside resp_owner.
- Back-to-back: a new grant is allowed in the same cycle a response returns; throughput is 1 access/cycle.
- Streak counter, width $clog2(MAX_D_STREAK+1):
  - +1 when if_req & grant_d.
  - Cleared on grant_if or !if_req.
  - Saturates at MAX_D_STREAK.
- CLEAR, synchronous:
  - resp_owner==OWN_IF in the cycle after CLEAR is forced to OWN_NONE, so the pending fetch is dropped with no if_valid.
  - Streak counter cleared.
  - An OWN_D response is not dropped; a store already issued stays committed.
  - Grants in the CLEAR cycle itself still occur.
- Reset (RESET_N=0, async): resp_owner=OWN_NONE, streak=0, all outputs 0 (stall outputs follow their combinational terms once RESET_N=1). Reset mid-access drops any pending response.

Decomposition:
- Package mem_arb_pkg: enum resp_owner_t {OWN_NONE, OWN_IF, OWN_D}; constant MAX_D_STREAK_DEFAULT=3.
- Sub-module arb_streak_counter (params MAX; inputs inc, clr; output at_max) holds the saturating starvation counter.
- Top level holds the grant logic, the response register and the muxes.

Test Plan:
- Fetch only: if_req=1, if_addr=0..3 for 4 cycles, RAM word k = 0x100+k → if_valid every cycle from cycle 2, if_rdata 0x100..0x103, if_stall=0 throughout.
- Collision: if_req=1 and d_read=1 at d_addr=0x20 (RAM 0xDEAD) → cycle 1 d granted, if_stall=1; cycle 2 d_valid=1, d_rdata=0xDEAD; fetch granted in cycle 2.
- Starvation guard, MAX_D_STREAK=3: continuous d_read plus if_req → d granted 3 cycles, 4th cycle grant_if=1 and d_stall=1; if_valid next cycle; pattern repeats.
- Store then load same address: d_write addr 5 data 0xCAFE, then d_read addr 5 → d_valid both cycles, load returns 0xCAFE, d_rdata=0 on the store response.
- CLEAR: fetch granted at addr 7, CLEAR asserted the same cycle → next cycle if_valid=0, mem_re was 1; with a data grant in the same CLEAR cycle, d_valid still asserts.
- Async reset: RESET_N low mid-stream between clock edges → immediately if_valid=d_valid=0 and mem_we=mem_re=0; after release, first grant behaves as from idle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } resp_owner_t;

    localparam int MAX_D_STREAK_DEFAULT = 3;

    // Owner of next cycle's response, given this cycle's grants and flush.
    // A flush only drops a fetch; a data response is never discarded.
    function automatic resp_owner_t next_owner(input logic grant_if,
                                               input logic grant_d,
                                               input logic clear);
        resp_owner_t own;
        own = OWN_NONE;
        if (grant_d) begin
            own = OWN_D;
        end else if (grant_if && !clear) begin
            own = OWN_IF;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side fetch/data ports and RAM-side pins around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: stall flags travel on this bundle back to the core.
interface mem_port_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
);
    // fetch port
    logic                 if_req;
    logic [ADDR_SIZE-1:0] if_addr;
    logic [DATA_SIZE-1:0] if_rdata;
    logic                 if_valid;
    logic                 if_stall;

    // data port
    logic                 d_read;
    logic                 d_write;
    logic [ADDR_SIZE-1:0] d_addr;
    logic [DATA_SIZE-1:0] d_wdata;
    logic [DATA_SIZE-1:0] d_rdata;
    logic                 d_valid;
    logic                 d_stall;

    // unified RAM
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [DATA_SIZE-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    // Core plus RAM side.
    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Counts consecutive cycles the fetch port was denied while requesting.
// Latency: at_max reflects the count registered at the previous edge.
// Backpressure: none; saturates at MAX and holds until cleared.
module arb_streak_counter #(
    parameter int MAX = 3
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    // Saturating count of denied fetch cycles; clear has priority.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered single-port RAM between fetch and data ports.
// Latency: exactly 1 cycle from grant to valid; 1 access per cycle.
// Backpressure: data wins unless fetch has been denied MAX_D_STREAK cycles; loser sees stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDR_SIZE    = 10,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                CLEAR,
    mem_port_arbiter_if.slave   bus
);
    logic        d_req;
    logic        grant_d;
    logic        grant_if;
    logic        streak_at_max;
    logic        streak_inc;
    logic        streak_clr;
    resp_owner_t resp_owner;
    logic        resp_is_read;

    assign d_req = bus.d_read | bus.d_write;

    // Grants are masked while reset is held so the RAM sees no strobes
    // the instant RESET_N falls, not just at the next edge.
    assign grant_d  = RESET_N & d_req & !(bus.if_req & streak_at_max);
    assign grant_if = RESET_N & bus.if_req & !grant_d;

    assign bus.if_stall = RESET_N & bus.if_req & !grant_if;
    assign bus.d_stall  = RESET_N & d_req & !grant_d;

    assign streak_inc = bus.if_req & grant_d;
    assign streak_clr = grant_if | !bus.if_req | CLEAR;

    arb_streak_counter #(
        .MAX (MAX_D_STREAK)
    ) u_streak (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (streak_inc),
        .clr     (streak_clr),
        .at_max  (streak_at_max)
    );

    // Steer the granted port onto the RAM pins; a read+write collision
    // on the data port is treated as a write.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        if (grant_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_we    = bus.d_write;
            bus.mem_re    = bus.d_read & !bus.d_write;
        end else if (grant_if) begin
            bus.mem_addr  = bus.if_addr;
            bus.mem_re    = 1'b1;
        end
    end

    // Remember who owns the RAM output next cycle and whether it was a load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            resp_owner   <= OWN_NONE;
            resp_is_read <= 1'b0;
        end else begin
            resp_owner   <= next_owner(grant_if, grant_d, CLEAR);
            resp_is_read <= grant_d & bus.d_read & !bus.d_write;
        end
    end

    assign bus.if_valid = (resp_owner == OWN_IF);
    assign bus.d_valid  = (resp_owner == OWN_D);
    assign bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (bus.d_valid && resp_is_read) ? bus.mem_rdata : '0;

    // The core must never issue a load and a store in the same cycle.
    a_no_read_write: assert property (@(posedge CLK) disable iff (!RESET_N)
        !(bus.d_read && bus.d_write));

endmodule
